// File: rtl/mult_share_arbiter_pkg.sv
// Shared types for the multiplier-sharing arbiter: FSM state encoding and index-width helper.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    localparam int R_DEFAULT     = 3;
    localparam int IDX_W_DEFAULT = $clog2(R_DEFAULT);

    // A one-requester build still needs a 1-bit index.
    function automatic int idx_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr_i, wrapping; ptr_i itself is searched last.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int R  = 3,
    localparam int IW = idx_w(R)
) (
    input  logic [R-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [R-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= R; k++) begin
            cand = IW'((int'(ptr_i) + k) % R);
            if (!found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                found       = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one start/ready sequential multiplier among R requesters; one job in flight.
// Optional WAIT watchdog under MULT_ARB_TIMEOUT_EN aborts a stuck job with rsp_err_o.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int R       = 3,
    parameter int TIMEOUT = 64
) (
    input  logic             clock_i,
    input  logic             n_reset_i,
    input  logic [R-1:0]     req_valid_i,
    input  logic [R*N-1:0]   req_a_i,
    input  logic [R*N-1:0]   req_b_i,
    output logic [R-1:0]     req_ready_o,
    output logic [R-1:0]     rsp_valid_o,
    output logic [2*N-1:0]   rsp_prod_o,
    output logic             rsp_err_o,
    output logic             mul_start_o,
    output logic [N-1:0]     mul_a_o,
    output logic [N-1:0]     mul_b_o,
    input  logic             mul_ready_i,
    input  logic [2*N-1:0]   mul_prod_i
);

    localparam int IW = idx_w(R);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, owner_q;
    logic [N-1:0]    a_q, b_q;
    logic [2*N-1:0]  prod_q;
    logic [R-1:0]    gnt_vec;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            xfer;
    logic            expire;

    rr_arbiter #(.R(R)) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt_vec),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign xfer = (state_q == IDLE) && gnt_any;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    // Fires on the TIMEOUT-th WAIT cycle without a ready.
    assign expire = (state_q == WAIT) && !mul_ready_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clock_i) begin
        if (!n_reset_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == LAUNCH) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (xfer) begin
                err_q <= 1'b0;
            end else if (expire) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (!n_reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (mul_ready_i || expire) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset pointer at R-1 so requester 0 is searched first.
    always_ff @(posedge clock_i) begin
        if (!n_reset_i) begin
            ptr_q   <= IW'(R - 1);
            owner_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            if (xfer) begin
                a_q     <= req_a_i[int'(gnt_idx)*N +: N];
                b_q     <= req_b_i[int'(gnt_idx)*N +: N];
                owner_q <= gnt_idx;
                ptr_q   <= gnt_idx;
            end
            if (state_q == WAIT && mul_ready_i) begin
                prod_q <= mul_prod_i;
            end else if (expire) begin
                prod_q <= '0;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_prod_o  = '0;
        rsp_err_o   = 1'b0;
        mul_start_o = 1'b0;
        case (state_q)
            IDLE:   req_ready_o = n_reset_i ? gnt_vec : '0;
            LAUNCH: mul_start_o = 1'b1;
            ACK: begin
                mul_start_o          = 1'b1;
                rsp_valid_o[owner_q] = 1'b1;
                rsp_prod_o           = prod_q;
`ifdef MULT_ARB_TIMEOUT_EN
                rsp_err_o            = err_q;
`endif
            end
            default: ;
        endcase
    end

    assign mul_a_o = a_q;
    assign mul_b_o = b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed vector table, hand sequences for reset/pointer/timeout corners,
// then random traffic against a round-robin plus arithmetic reference model.
module tb_mult_share_arbiter;

    localparam int N  = 4;
    localparam int R  = 3;
    localparam int TO = 8;
`ifdef MULT_ARB_TIMEOUT_EN
    localparam int BUSY = 5;
`else
    localparam int BUSY = 9;
`endif
    localparam int LAT = 3 + BUSY;

    logic           clk;
    logic           n_reset;
    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_a, req_b;
    logic [R-1:0]   req_ready, rsp_valid;
    logic [2*N-1:0] rsp_prod;
    logic           rsp_err, mul_start;
    logic [N-1:0]   mul_a, mul_b;
    logic           mul_ready;
    logic [2*N-1:0] mul_prod;

    int errors = 0;
    int checks = 0;

    mult_share_arbiter #(.N(N), .R(R), .TIMEOUT(TO)) dut (
        .clock_i     (clk),
        .n_reset_i   (n_reset),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_prod_o  (rsp_prod),
        .rsp_err_o   (rsp_err),
        .mul_start_o (mul_start),
        .mul_a_o     (mul_a),
        .mul_b_o     (mul_b),
        .mul_ready_i (mul_ready),
        .mul_prod_i  (mul_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: start launches a BUSY-cycle job, the next start acknowledges/aborts.
    int             mb_busy;
    logic           mb_done;
    logic [2*N-1:0] mb_prod;
    logic           hang, glitch;

    assign mul_ready = mb_done | glitch;
    assign mul_prod  = mb_done ? mb_prod : (glitch ? 8'hAA : 8'h00);

    always @(posedge clk) begin
        if (!n_reset) begin
            mb_busy <= 0;
            mb_done <= 1'b0;
            mb_prod <= '0;
        end else if (mul_start && (mb_done || mb_busy > 0)) begin
            mb_busy <= 0;
            mb_done <= 1'b0;
        end else if (mul_start) begin
            mb_busy <= hang ? 100000 : BUSY;
            mb_prod <= mul_a * mul_b;
        end else if (mb_busy > 0) begin
            mb_busy <= mb_busy - 1;
            if (mb_busy == 1) mb_done <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        req_valid[i]       = 1'b1;
        req_a[i*N +: N]    = a;
        req_b[i*N +: N]    = b;
    endtask

    // Called at a negedge with n_reset high; leaves reset asserted across exactly one posedge.
    task automatic do_reset(input string tag);
        req_valid = '0;
        n_reset   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " req_ready"}, req_ready, 0);
        chk({tag, " rsp_valid"}, rsp_valid, 0);
        chk({tag, " rsp_prod"},  rsp_prod,  0);
        chk({tag, " rsp_err"},   rsp_err,   0);
        chk({tag, " mul_start"}, mul_start, 0);
        chk({tag, " mul_a"},     mul_a,     0);
        chk({tag, " mul_b"},     mul_b,     0);
        n_reset = 1'b1;
    endtask

    // Entry: next negedge is an IDLE cycle with requests already driven. Exit: at the ACK negedge.
    task automatic run_job(input string tag, input int who, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] prod, input logic err, input int lat_exp, input bit keep);
        int lat, starts;
        bit stable, got;
        @(negedge clk);
        chk({tag, " grant"}, req_ready, 32'd1 << who);
        chk({tag, " pulse width"}, rsp_valid, 0);
        @(posedge clk);
        #1;
        if (!keep) req_valid[who] = 1'b0;
        lat = 0; starts = 0; stable = 1'b1; got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (mul_start) starts++;
            if (mul_a !== a || mul_b !== b) stable = 1'b0;
            if (rsp_valid != '0) got = 1'b1;
        end
        chk({tag, " latency"},   lat, lat_exp);
        chk({tag, " rsp_valid"}, rsp_valid, 32'd1 << who);
        chk({tag, " rsp_prod"},  rsp_prod, prod);
        chk({tag, " rsp_err"},   rsp_err, err);
        chk({tag, " starts"},    starts, 2);
        chk({tag, " operands"},  stable, 1);
    endtask

    typedef struct {
        int         who;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
    } vec_t;

    vec_t       tbl[5];
    logic [3:0] fa[R];
    logic [3:0] fb[R];
    int         fp[R];
    int         ford[5];
    logic [3:0] pa[R];
    logic [3:0] pb[R];
    bit         pend[R];
    int         last, g, rcnt, scnt;
    bit         anyp;

    initial begin
        n_reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; hang = 1'b0; glitch = 1'b0;
        tbl[0] = '{0, 4'd3,  4'd5,  8'd15};
        tbl[1] = '{1, 4'd15, 4'd15, 8'd225};
        tbl[2] = '{2, 4'd0,  4'd9,  8'd0};
        tbl[3] = '{1, 4'd15, 4'd0,  8'd0};
        tbl[4] = '{2, 4'd12, 4'd11, 8'd132};
        fa = '{4'd2, 4'd4, 4'd6}; fb = '{4'd3, 4'd5, 4'd7}; fp = '{6, 20, 42};
        ford = '{0, 1, 2, 0, 1};

        @(negedge clk);
        do_reset("rst0");
        sync();
        for (int t = 0; t < 5; t++) begin
            set_req(tbl[t].who, tbl[t].a, tbl[t].b);
            run_job("vec", tbl[t].who, tbl[t].a, tbl[t].b, tbl[t].prod, 1'b0, LAT, 1'b0);
        end

        // Fairness with all three held valid through their own responses
        @(negedge clk);
        do_reset("rst1");
        sync();
        for (int i = 0; i < R; i++) set_req(i, fa[i], fb[i]);
        for (int i = 0; i < 5; i++)
            run_job("fair", ford[i], fa[ford[i]], fb[ford[i]], 8'(fp[ford[i]]), 1'b0, LAT, 1'b1);

        // Pointer sits at 1: requester 2 before 0
        req_valid = '0;
        set_req(0, 4'd1, 4'd9);
        set_req(2, 4'd9, 4'd9);
        run_job("ptr2", 2, 4'd9, 4'd9, 8'd81, 1'b0, LAT, 1'b0);
        run_job("ptr0", 0, 4'd1, 4'd9, 8'd9, 1'b0, LAT, 1'b0);

        // Idle cycles with a stray mul_ready: nothing happens, pointer stays at 0
        @(negedge clk);
        sync();
        glitch = 1'b1; rcnt = 0; scnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != '0) rcnt++;
            if (mul_start) scnt++;
        end
        glitch = 1'b0;
        chk("stray ready rsp", rcnt, 0);
        chk("stray ready start", scnt, 0);
        sync();
        set_req(0, 4'd6, 4'd6);
        set_req(1, 4'd7, 4'd3);
        run_job("idle ptr1", 1, 4'd7, 4'd3, 8'd21, 1'b0, LAT, 1'b0);
        run_job("idle ptr0", 0, 4'd6, 4'd6, 8'd36, 1'b0, LAT, 1'b0);

        // Reset while WAITing on requester 0's job
        set_req(0, 4'd3, 4'd3);
        @(negedge clk);
        chk("rstw grant", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        do_reset("rstw");
        rcnt = 0; scnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid != '0) rcnt++;
            if (mul_start) scnt++;
        end
        chk("rstw dropped rsp", rcnt, 0);
        chk("rstw no start", scnt, 0);
        sync();
        set_req(0, 4'd2, 4'd2);
        set_req(1, 4'd2, 4'd5);
        run_job("rstw first0", 0, 4'd2, 4'd2, 8'd4, 1'b0, LAT, 1'b0);
        run_job("rstw then1", 1, 4'd2, 4'd5, 8'd10, 1'b0, LAT, 1'b0);

`ifdef MULT_ARB_TIMEOUT_EN
        hang = 1'b1;
        set_req(1, 4'd5, 4'd5);
        run_job("timeout", 1, 4'd5, 4'd5, 8'd0, 1'b1, 2 + TO, 1'b0);
        hang = 1'b0;
        set_req(2, 4'd3, 4'd4);
        run_job("post timeout", 2, 4'd3, 4'd4, 8'd12, 1'b0, LAT, 1'b0);
`endif

        // Random traffic against round-robin reference
        @(negedge clk);
        do_reset("rst2");
        sync();
        last = R - 1;
        for (int i = 0; i < R; i++) pend[i] = 1'b0;
        for (int j = 0; j < 40; j++) begin
            anyp = 1'b0;
            for (int i = 0; i < R; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pa[i] = 4'($urandom_range(0, 15));
                    pb[i] = 4'($urandom_range(0, 15));
                    set_req(i, pa[i], pb[i]);
                end
                if (pend[i]) anyp = 1'b1;
            end
            if (!anyp) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    chk("rnd idle ready", req_ready, 0);
                end
                sync();
                g = $urandom_range(0, R - 1);
                pend[g] = 1'b1;
                pa[g] = 4'($urandom_range(0, 15));
                pb[g] = 4'($urandom_range(0, 15));
                set_req(g, pa[g], pb[g]);
            end
            g = -1;
            for (int k = 1; k <= R; k++)
                if (g < 0 && pend[(last + k) % R]) g = (last + k) % R;
            run_job("rnd", g, pa[g], pb[g], 8'(int'(pa[g]) * int'(pb[g])), 1'b0, LAT, 1'b0);
            pend[g] = 1'b0;
            last = g;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
